// File: rtl/mips32_bitops_pkg.sv
// Shared definitions for the mips32 bit-manipulation unit.
// Optional feature macro: MIPS32_BITOPS_CLZ_EN (hardware count-leading-zeros).
package mips32_bitops_pkg;

    // Default datapath sizing
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    // Operation encoding as presented on the op port
    localparam logic [1:0] OP_POPCNT = 2'b00;
    localparam logic [1:0] OP_SRL    = 2'b01;
    localparam logic [1:0] OP_SLL    = 2'b10;
    localparam logic [1:0] OP_CLZ    = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mips32_bitops_iter.sv
// Combinational single-iteration step of the bit-manipulation unit.
// Optional feature macro: MIPS32_BITOPS_CLZ_EN (hardware count-leading-zeros).
module mips32_bitops_iter
    import mips32_bitops_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] shadow,
    input  logic [CNT_W-1:0] acc,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] shadow_nxt,
    output logic [CNT_W-1:0] acc_nxt,
    output logic [CNT_W-1:0] count_nxt,
    output logic             finish
);

    // One step of the selected operation; state is left untouched unless the op advances it
    always_comb begin
        shadow_nxt = shadow;
        acc_nxt    = acc;
        count_nxt  = count;
        finish     = 1'b0;
        case (op)
            OP_POPCNT: begin
                acc_nxt    = acc + CNT_W'(shadow[0]);
                shadow_nxt = shadow >> 1;
                finish     = (shadow_nxt == '0);
            end
            OP_SRL: begin
                if (count != '0) begin
                    shadow_nxt = shadow >> 1;
                    count_nxt  = count - 1'b1;
                end
                finish = (count_nxt == '0);
            end
            OP_SLL: begin
                if (count != '0) begin
                    shadow_nxt = shadow << 1;
                    count_nxt  = count - 1'b1;
                end
                finish = (count_nxt == '0);
            end
            default: begin
`ifdef MIPS32_BITOPS_CLZ_EN
                // A set MSB ends the scan; an all-zero operand stops once acc hits WIDTH
                if (shadow[WIDTH-1]) begin
                    finish = 1'b1;
                end else begin
                    acc_nxt    = acc + 1'b1;
                    shadow_nxt = shadow << 1;
                    finish     = (acc_nxt == CNT_W'(WIDTH));
                end
`else
                // Unsupported op: finish immediately, the top flags the error
                finish = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/mips32_bitops_unit.sv
// Multi-cycle bit-manipulation unit: POPCNT, SRL, SLL and optional CLZ, one bit per cycle.
// Handshakes: a transfer happens on a rising edge where valid && ready; the unit holds
// start_ready only in IDLE and holds res_valid plus all result fields stable until res_ready.
// Optional feature macro: MIPS32_BITOPS_CLZ_EN (hardware count-leading-zeros).
module mips32_bitops_unit
    import mips32_bitops_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [4:0]       src_b,
    input  logic [4:0]       rd,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [4:0]       res_rd,
    output logic             res_err,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] shadow_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    logic [4:0]       rd_q;

    logic [WIDTH-1:0] it_shadow;
    logic [CNT_W-1:0] it_acc;
    logic [CNT_W-1:0] it_count;
    logic             it_finish;
    logic             accept;

    assign accept = (state == S_IDLE) && start_valid;

    mips32_bitops_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .op         (op_q),
        .shadow     (shadow_q),
        .acc        (acc_q),
        .count      (count_q),
        .shadow_nxt (it_shadow),
        .acc_nxt    (it_acc),
        .count_nxt  (it_count),
        .finish     (it_finish)
    );

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_valid) state_nxt = S_RUN;
            S_RUN:   if (it_finish)   state_nxt = S_DONE;
            S_DONE:  if (res_ready)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch on accept, then one iteration per cycle while running
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_POPCNT;
            shadow_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            rd_q     <= '0;
        end else if (accept) begin
            op_q     <= op;
            shadow_q <= src_a;
            acc_q    <= '0;
            count_q  <= CNT_W'(src_b);
            rd_q     <= rd;
        end else if (state == S_RUN) begin
            shadow_q <= it_shadow;
            acc_q    <= it_acc;
            count_q  <= it_count;
        end
    end

    assign start_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign res_valid   = (state == S_DONE);

    // Result fields are driven only while the result is offered, zero otherwise
    always_comb begin
        res_data = '0;
        res_rd   = '0;
        res_err  = 1'b0;
        if (state == S_DONE) begin
            res_rd = rd_q;
            case (op_q)
                OP_POPCNT:       res_data = WIDTH'(acc_q);
                OP_SRL, OP_SLL:  res_data = shadow_q;
                default: begin
`ifdef MIPS32_BITOPS_CLZ_EN
                    res_data = WIDTH'(acc_q);
`else
                    res_err  = 1'b1;
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/mips32_bitops_unit.md
# mips32_bitops_unit

Multi-cycle bit-manipulation execution unit for the mips32 pipelined core. It sits downstream of ID/EX and upstream of EX/MEM write-back. It executes population count, logical shifts and count-leading-zeros in hardware, replacing the software loops of AND/ADDI/branch sequences. Operands are accepted through a valid/ready handshake, iterated one bit per cycle, and the result is returned through a second valid/ready handshake together with its destination register index.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- CNT_W, 6, iteration counter and popcount width (must hold WIDTH)

Ports:
- clk1  in  1  single clock; rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  request valid
- start_ready  out  1  unit can accept a request
- op  in  2  00 POPCNT, 01 SRL, 10 SLL, 11 CLZ
- src_a  in  WIDTH  operand
- src_b  in  5  shift amount; ignored for POPCNT/CLZ
- rd  in  5  destination register index, passed through
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  result
- res_rd  out  5  latched rd
- res_err  out  1  illegal op flag, qualified by res_valid
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid, latch op, src_a into shadow register, src_b into count, and rd.
  - Clear the accumulator and go to RUN.
- RUN performs one iteration per cycle:
  - POPCNT: acc += shadow[0]; shadow >>= 1; finish when the post-shift shadow is 0. Zero input finishes after 1 iteration with result 0.
  - SRL/SLL: if count != 0, shift shadow by 1 and decrement count; finish when count reaches 0 after the step. Amount 0 takes 1 iteration with the value unchanged. Logical shifts only; vacated bits are 0.
  - CLZ: if shadow[WIDTH-1]=1, finish. Otherwise acc++ and shadow <<= 1. Also finish when acc reaches WIDTH. Zero input gives 32.
- Iteration counts:
  - POPCNT: max(1, index of highest set bit + 1).
  - SRL/SLL: max(1, src_b).
  - CLZ: min(32, result + 1).
- DONE:
  - res_valid=1.
  - res_data = acc zero-extended (POPCNT/CLZ) or shadow (shifts); res_rd = latched rd.
  - All result outputs are held stable until res_ready. On res_valid && res_ready, go to IDLE.
- The unit never accepts a request in RUN or DONE. start_valid there is ignored and src inputs are not sampled.
- Reset values: res_valid=0, res_data=0, res_rd=0, res_err=0, busy=0, start_ready=1 (state IDLE).
- Reset asserted mid-operation aborts immediately and asynchronously; no partial result is emitted.

## Timing
- Accept at edge E0. Iterations at E1..En; the edge at En sets res_valid.
- Latency from accept to res_valid is n+1 edges (min 2, max 33).
- Handshake completes at the first edge where res_valid && res_ready. At that edge res_valid drops and start_ready rises.
- No same-cycle back-to-back turnaround: the next accept happens no earlier than the edge after DONE exits.

## Configuration
- MIPS32_BITOPS_CLZ_EN defined: op 11 runs CLZ as specified; res_err is always 0.
- Undefined: no CLZ logic is synthesised. Op 11 takes 1 iteration and returns res_data=0, res_err=1.

## Structure
- Package mips32_bitops_pkg holds:
  - op encoding constants (OP_POPCNT, OP_SRL, OP_SLL, OP_CLZ)
  - FSM state enum
  - default WIDTH/CNT_W
- Sub-module mips32_bitops_iter: combinational single-iteration step.
  - Inputs: op, shadow, acc, count.
  - Outputs: next shadow, acc, count, finish.
  - The top level owns the FSM, latches and handshakes.

## Test plan
- POPCNT src_a=0x0000001D: res_data=4 with res_valid after E5. Also src_a=0xFFFFFFFF gives 32 after 32 iterations, and src_a=0 gives 0 after E1.
- SRL 0x80000000 by 31 gives 0x00000001 after 31 iterations. SRL 0x1234 by 0 gives 0x1234 after E1. Shifts carry no sign extension.
- SLL 0x00000001 by 4 gives 0x00000010. res_rd equals the rd supplied at accept (e.g. 9).
- CLZ 0x00010000 gives 15 after 16 iterations; CLZ 0 gives 32.
  - With MIPS32_BITOPS_CLZ_EN undefined, op 11 gives res_data=0, res_err=1.
- Backpressure: hold res_ready=0 for 3 cycles. res_data/res_rd/res_valid stay stable, start_ready=0, and a start_valid pulse during busy is not accepted.
- Reset: deassert rst_n during RUN. All outputs go to reset values immediately without a clock. After release, a new POPCNT 0x7 request gives 3.
